// File: rtl/md_pkg.sv
// Shared encodings and default timing for the multiply/divide unit.
package md_pkg;

  // Operation codes arriving from the EX stage; code 7 is unused and behaves as NONE.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  // Control FSM states.
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Default geometry and latencies.
  localparam int MD_WIDTH_DEF       = 32;
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W_DEF       = 4;

endpackage

// File: rtl/md_calc.sv
// Combinational result generator: maps a latched op and operands to {hi, lo}.
// All signedness, divide-by-zero and signed-overflow rules live here.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEF
) (
  input  md_op_e             i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_hi_lo
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL1  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MOSTN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0]        w_prod_u;
  logic                      w_is_signed;
  logic                      w_a_neg;
  logic                      w_b_neg;
  logic [WIDTH-1:0]          w_dvd;
  logic [WIDTH-1:0]          w_dvs_raw;
  logic [WIDTH-1:0]          w_dvs;
  logic [WIDTH-1:0]          w_q_mag;
  logic [WIDTH-1:0]          w_r_mag;
  logic [WIDTH-1:0]          w_quot;
  logic [WIDTH-1:0]          w_rem;
  logic                      w_div_zero;
  logic                      w_div_ovf;

  // Both products are formed at full 2*WIDTH precision.
  assign w_prod_s = $signed(i_a) * $signed(i_b);
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // One unsigned divider serves both DIV and DIVU: signed operands are
  // reduced to magnitudes first and the signs are reapplied afterwards.
  assign w_is_signed = (i_op == MD_DIV);
  assign w_a_neg     = w_is_signed & i_a[WIDTH-1];
  assign w_b_neg     = w_is_signed & i_b[WIDTH-1];
  assign w_dvd       = w_a_neg ? (-i_a) : i_a;
  assign w_dvs_raw   = w_b_neg ? (-i_b) : i_b;
  // Substitute 1 for a zero divisor so the divider never sees x-producing input;
  // the zero case is overridden below anyway.
  assign w_dvs       = (w_dvs_raw == '0) ? ONE : w_dvs_raw;
  assign w_q_mag     = w_dvd / w_dvs;
  assign w_r_mag     = w_dvd % w_dvs;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_quot      = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
  assign w_rem       = w_a_neg ? (-w_r_mag) : w_r_mag;

  assign w_div_zero  = (i_b == '0);
  assign w_div_ovf   = w_is_signed && (i_a == MOSTN) && (i_b == ALL1);

  // Select the {hi, lo} pair for the latched operation.
  always_comb begin
    o_hi_lo = '0;
    case (i_op)
      MD_MULT:  o_hi_lo = w_prod_s;
      MD_MULTU: o_hi_lo = w_prod_u;
      MD_DIV, MD_DIVU: begin
        if (w_div_zero) begin
          o_hi_lo = {i_a, ALL1};
        end else if (w_div_ovf) begin
          o_hi_lo = {{WIDTH{1'b0}}, MOSTN};
        end else begin
          o_hi_lo = {w_rem, w_quot};
        end
      end
      default: o_hi_lo = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers. Holds busy for a
// fixed number of cycles per operation, then commits the result to HI/LO.
// It owns no stall logic: ops arriving while busy are dropped.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = MD_WIDTH_DEF,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = MD_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  md_state_e          r_state;
  md_state_e          w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_hi_next;
  logic [WIDTH-1:0]   w_lo_next;
  logic               w_start;
  md_op_e             w_op;
  logic [2*WIDTH-1:0] w_calc;

  assign w_op = md_op_e'(md_op);

  // Result is always derived from the latched operands, never the live inputs.
  md_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .i_op    (r_op),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_hi_lo (w_calc)
  );

  // Next-state, counter and HI/LO write decisions.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_start      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (!cancel) begin
          case (w_op)
            MD_MULT, MD_MULTU: begin
              w_start      = 1'b1;
              w_cnt_next   = CNT_MULT;
              w_state_next = MD_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              w_start      = 1'b1;
              w_cnt_next   = CNT_DIV;
              w_state_next = MD_BUSY;
            end
            MD_MTHI: w_hi_next = rs_val;
            MD_MTLO: w_lo_next = rs_val;
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        if (cancel) begin
          // Abort wins over a commit on the same edge.
          w_state_next = MD_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_ONE) begin
          {w_hi_next, w_lo_next} = w_calc;
          w_state_next = MD_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_next = MD_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
    end
  end

  // Capture op and operands when an operation is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= MD_NONE;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_start) begin
      r_op <= w_op;
      r_a  <= rs_val;
      r_b  <= rt_val;
    end
  end

  assign busy = (r_state == MD_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage of the pipelined datapath, beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the EX stage.
- Holds busy for a configurable number of cycles, then commits the result to HI/LO.
- The hazard unit uses busy/start to stall mfhi/mflo and further MD instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (even, >= 8).
- MULT_CYCLES, 5, busy cycles for mult/multu (>= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (>= 1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  rising-edge clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- md_op  input  3  operation from EX stage; encodings from md_pkg.
- rs_val  input  WIDTH  operand A: dividend / multiplicand / mthi-mtlo data.
- rt_val  input  WIDTH  operand B: divisor / multiplier.
- cancel  input  1  abort any in-flight operation (exception/flush); HI/LO untouched.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register, registered.
- lo  output  WIDTH  LO register, registered.

Behaviour:
- Reset: hi=0, lo=0, busy=0, FSM=IDLE, counter=0. Reset overrides every input, including mid-operation; an in-flight result is discarded.
- md_op encodings: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- FSM states: IDLE, BUSY.
- IDLE:
  - md_op in MULT..DIVU with cancel=0: latch op and operands, load counter with the op's cycle count, go to BUSY.
  - MTHI: hi<=rs_val at this edge; no busy. MTLO: lo<=rs_val at this edge; no busy.
- BUSY: busy=1; counter decrements each cycle.
  - When counter reaches 1: the next edge writes hi/lo from the latched operands and returns to IDLE.
- Timing: op presented in cycle t → busy=1 in cycles t+1..t+N, where N = MULT_CYCLES or DIV_CYCLES. New hi/lo and busy=0 are visible from cycle t+N+1.
- Unit owns no stall logic: md_op arriving while BUSY is ignored, including MTHI/MTLO; the hazard unit must stall it.
- cancel=1 in BUSY: next edge returns to IDLE, busy=0, hi/lo unchanged.
- cancel=1 in IDLE: suppresses any md_op that cycle, including MTHI/MTLO.
- cancel in the same cycle as the committing edge: cancel wins; no write.
- Multiply:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH-bit product. MULTU: unsigned, same width.
  - hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide:
  - DIV: signed, quotient truncated toward zero; remainder takes the dividend's sign. DIVU: unsigned.
  - lo = quotient, hi = remainder.
  - Divisor 0: lo = all-ones, hi = rs_val (both signed and unsigned).
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- Results are computed from the latched operands, never the live inputs; operand changes during BUSY have no effect.

Decomposition:
- md_pkg holds:
  - md_op encodings (MD_NONE..MD_MTLO);
  - FSM state encodings (MD_IDLE, MD_BUSY);
  - default cycle-count constants.
- One combinational sub-module, md_calc (parameter WIDTH):
  - takes latched op/A/B, returns {hi_next, lo_next};
  - contains all signed/unsigned and div-by-zero/overflow rules.
- md_unit keeps the FSM, counter, operand latches and HI/LO registers.

Test Plan:
- Reset with prior hi=0x1234 → after one edge with reset=1: hi=0, lo=0, busy=0; repeat mid-BUSY → same, and no later commit.
- MULT rs=0xFFFFFFFF rt=0x00000002 at cycle t → busy=1 for t+1..t+5; hi=0xFFFFFFFF, lo=0xFFFFFFFE visible at t+6. MULTU with same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7) rt=2 → after 10 busy cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7 rt=0 → lo=0xFFFFFFFF, hi=0x00000007. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI rs=0xA5A5A5A5 in IDLE → hi=0xA5A5A5A5 the next cycle, busy stays 0. MTLO presented while BUSY → lo unchanged by it; only the MD commit value appears.
- Start DIV, assert cancel in busy cycle 4 → busy=0 the next cycle, hi/lo keep pre-start values; cancel on the commit cycle → no write. cancel together with MULT in IDLE → busy stays 0.
- Change rs_val/rt_val every cycle during BUSY → result matches the operands latched at start; randomised MULT/DIV pairs checked against a reference model for WIDTH=32 and WIDTH=16.
